// File: rtl/uart_pkg.sv
// Shared defaults for the UART receive FIFO slice.
package uart_pkg;

   localparam int unsigned DefDbit  = 8;
   localparam int unsigned DefDepth = 16;

   function automatic int unsigned ptr_width(int unsigned depth);
      return $clog2(depth);
   endfunction

   localparam int unsigned DefPtrW = ptr_width(DefDepth);

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver push side, consumer pop side and status flags of the RX FIFO.
interface uart_rx_fifo_if
   import uart_pkg::*;
#(
   parameter int unsigned DBIT  = DefDbit,
   parameter int unsigned DEPTH = DefDepth
) ();

   localparam int unsigned CntW = ptr_width(DEPTH) + 1;

   logic            rx_done;
   logic [DBIT-1:0] rx_dout;
   logic            m_valid;
   logic            m_ready;
   logic [DBIT-1:0] m_data;
   logic            full;
   logic            empty;
   logic [CntW-1:0] count;
   logic            overrun;
   logic            ovr_clr;

   modport slave (
      input  rx_done, rx_dout, m_ready, ovr_clr,
      output m_valid, m_data, full, empty, count, overrun
   );

   modport master (
      output rx_done, rx_dout, m_ready, ovr_clr,
      input  m_valid, m_data, full, empty, count, overrun
   );

endinterface

// File: rtl/uart_fifo_mem.sv
// FIFO storage: register array, synchronous write, asynchronous read, no reset.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int unsigned DBIT  = DefDbit,
   parameter int unsigned DEPTH = DefDepth
) (
   input  logic                       clk,
   input  logic                       we_i,
   input  logic [ptr_width(DEPTH)-1:0] waddr_i,
   input  logic [DBIT-1:0]            wdata_i,
   input  logic [ptr_width(DEPTH)-1:0] raddr_i,
   output logic [DBIT-1:0]            rdata_o
);

   logic [DBIT-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO behind the UART receiver, with sticky overrun flag.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DBIT  = DefDbit,
   parameter int unsigned DEPTH = DefDepth
) (
   input  logic          clk,
   input  logic          reset,
   uart_rx_fifo_if.slave bus
);

   localparam int unsigned PtrW = ptr_width(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            overrun_q, overrun_d;
   logic            full, empty, push, pop, drop;
   logic [DBIT-1:0] rdata;

   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(DEPTH));
   assign pop   = ~empty & bus.m_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push  = bus.rx_done & (~full | pop);
   assign drop  = bus.rx_done & full & ~pop;

   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      if (push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // A new drop wins over a simultaneous clear.
      if (drop) begin
         overrun_d = 1'b1;
      end else if (bus.ovr_clr) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   uart_fifo_mem #(
      .DBIT  (DBIT),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (bus.rx_dout),
      .raddr_i (rptr_q),
      .rdata_o (rdata)
   );

   assign bus.m_valid = ~empty;
   assign bus.m_data  = rdata;
   assign bus.full    = full;
   assign bus.empty   = empty;
   assign bus.count   = count_q;
   assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a monitor checks pops.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int unsigned DBIT  = 8;
   localparam int unsigned DEPTH = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   uart_rx_fifo_if #(.DBIT(DBIT), .DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(
      .DBIT  (DBIT),
      .DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [7:0]  exp_q[$];
   int          mcount   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs and advance the reference occupancy model.
   task automatic step(input bit done, input logic [7:0] dout, input bit rdy, input bit clr);
      bit pop_m;
      bit push_m;
      bus.rx_done = done;
      bus.rx_dout = dout;
      bus.m_ready = rdy;
      bus.ovr_clr = clr;
      pop_m  = rdy && (mcount > 0);
      push_m = done && ((mcount < int'(DEPTH)) || pop_m);
      if (push_m) exp_q.push_back(dout);
      mcount = mcount + int'(push_m) - int'(pop_m);
      @(posedge clk);
      #1;
      bus.rx_done = 1'b0;
      bus.m_ready = 1'b0;
      bus.ovr_clr = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && bus.m_valid && bus.m_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got 0x%0h, expected no entry at %0t", bus.m_data,
                     $time);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.m_data !== e) begin
               n_fail++;
               $display("FAIL pop_data: got 0x%0h, expected 0x%0h at %0t", bus.m_data, e,
                        $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rx_done = 1'b0;
      bus.rx_dout = '0;
      bus.m_ready = 1'b0;
      bus.ovr_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_empty",   32'(bus.empty),   32'd1);
      check("rst_full",    32'(bus.full),    32'd0);
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_count",   32'(bus.count),   32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);

      // Single byte falls through the next cycle.
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      check("a5_m_valid", 32'(bus.m_valid), 32'd1);
      check("a5_m_data",  32'(bus.m_data),  32'hA5);
      check("a5_count",   32'(bus.count),   32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("a5_empty", 32'(bus.empty), 32'd1);

      // m_ready while empty is ignored.
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("idle_pop_count", 32'(bus.count), 32'd0);

      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      check("fill_full",  32'(bus.full),  32'd1);
      check("fill_count", 32'(bus.count), 32'd16);

      // Drop while full; a drop coincident with clear keeps the flag.
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      check("drop_overrun", 32'(bus.overrun), 32'd1);
      check("drop_count",   32'(bus.count),   32'd16);
      step(1'b1, 8'hFF, 1'b0, 1'b1);
      check("drop_clr_overrun", 32'(bus.overrun), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("clr_overrun", 32'(bus.overrun), 32'd0);

      // Push and pop together while full.
      step(1'b1, 8'h55, 1'b1, 1'b0);
      check("fullpp_overrun", 32'(bus.overrun), 32'd0);
      check("fullpp_count",   32'(bus.count),   32'd16);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_empty", 32'(bus.empty), 32'd1);
      check("drain_count", 32'(bus.count), 32'd0);

      // Push and pop together while empty: push only.
      step(1'b1, 8'h3C, 1'b1, 1'b0);
      check("emptypp_count",  32'(bus.count),  32'd1);
      check("emptypp_m_data", 32'(bus.m_data), 32'h3C);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      check("pre_rst_count", 32'(bus.count), 32'd5);
      reset = 1'b1;
      exp_q.delete();
      mcount = 0;
      #1;
      check("mid_rst_count",   32'(bus.count),   32'd0);
      check("mid_rst_empty",   32'(bus.empty),   32'd1);
      check("mid_rst_overrun", 32'(bus.overrun), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Mixed traffic long enough to wrap both pointers.
      for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h40 + i), (i % 3) != 0, 1'b0);
      check("wrap_count", 32'(bus.count), 32'(mcount));
      for (int k = 0; k < 64 && mcount > 0; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_empty",     32'(bus.empty),   32'd1);
      check("scoreboard_end", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DBIT, default 8, data word width in bits; matches the receiver's data width.
REQ-002 Parameter: DEPTH, default 16, number of entries; power of two, minimum 2.
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: rx_done  input  1  one-cycle write strobe from the UART receiver.
REQ-006 Port: rx_dout  input  DBIT  received byte; valid in the cycle rx_done is high.
REQ-007 Port: m_valid  output  1  head entry available (equals not empty).
REQ-008 Port: m_ready  input  1  consumer accepts head entry.
REQ-009 Port: m_data  output  DBIT  head entry, first-word-fall-through.
REQ-010 Port: full  output  1  count equals DEPTH.
REQ-011 Port: empty  output  1  count equals 0.
REQ-012 Port: count  output  clog2(DEPTH)+1  number of stored entries.
REQ-013 Port: overrun  output  1  sticky flag: a byte was dropped.
REQ-014 Port: ovr_clr  input  1  synchronous clear of overrun.

Function
REQ-015 Push: rx_done high and (not full, or pop in the same cycle) SHALL store rx_dout at the write pointer on that clock edge.
REQ-016 Pop: m_valid and m_ready both high SHALL advance the read pointer on that clock edge.
REQ-017 m_data SHALL present the head entry combinationally from storage, with zero-cycle latency while m_valid is high; m_data is don't-care while empty.
REQ-018 A pushed byte SHALL appear on m_data, with m_valid high, in the cycle after the rx_done cycle.
REQ-019 m_ready while empty SHALL be ignored: no pointer or count change.
REQ-020 Push while full without a simultaneous pop SHALL drop the byte, leave pointers and count unchanged, and set overrun on the next edge.
REQ-021 Push and pop together while full SHALL both occur: count stays DEPTH, no overrun.
REQ-022 Push and pop together while empty SHALL perform the push only: count becomes 1.
REQ-023 Push and pop together in any other state SHALL both occur, leaving count unchanged.
REQ-024 count SHALL update by +1 on push-only, -1 on pop-only, and 0 otherwise, and SHALL never exceed DEPTH or go below 0.
REQ-025 Pointers SHALL be clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
REQ-026 full, empty and m_valid SHALL be decoded from registered count; they are not separately registered.
REQ-027 overrun SHALL stay set until ovr_clr; if ovr_clr and a new drop occur in the same cycle, overrun SHALL remain set.

Reset
REQ-028 Reset SHALL clear both pointers, count and overrun immediately, independent of clk.
REQ-029 After reset: empty=1, full=0, m_valid=0, count=0, overrun=0.
REQ-030 Storage contents SHALL NOT be reset; reset mid-operation discards all entries.

Structure
REQ-031 Shared package uart_pkg SHALL hold the DBIT and DEPTH defaults and a pointer-width constant derived from DEPTH.
REQ-032 Storage SHALL be the sub-module uart_fifo_mem: a register array with a synchronous write port and an asynchronous read port.
REQ-033 Pointer, count and flag control SHALL live in uart_rx_fifo.

Verification
REQ-034 Reset, then rx_done with 0xA5 -> next cycle m_valid=1, m_data=0xA5, count=1.
REQ-035 16 pushes 0x00..0x0F with m_ready=0 -> full=1, count=16; then pop 16 times -> data 0x00..0x0F in order, then empty=1.
REQ-036 While full, push 0xFF with m_ready=0 -> overrun=1, count=16, and 0xFF never appears; ovr_clr -> overrun=0.
REQ-037 While full, push 0x55 with m_ready=1 -> overrun=0, count=16, and 0x55 emerges last.
REQ-038 While empty, push 0x3C with m_ready=1 -> count=1, then m_data=0x3C.
REQ-039 Assert reset with count=5 mid-stream -> immediately count=0, empty=1, overrun=0; 40 push/pop cycles then confirm pointer wrap with no data loss.
